// File: rtl/packet_assembler_pkg.sv
// Shared definitions for the packet assembler: the NIC-defines set (flit
// format, packet length, flit type codes, slot state codes) and the typed
// views of those codes used by packet_slot and packet_assembler.
// Optional error counter is enabled by defining PKT_ASM_ERR_CNT_EN.

`ifndef NIC_DEFINES_V
`define NIC_DEFINES_V
// ---- NIC-defines ----
`define FLIT_WIDTH          16
`define FLIT_TYPE_BITS      15:14
`define MAX_PACKET_LENGHT   5
`define FLIT_TYPE_BODY      2'b00
`define FLIT_TYPE_TAIL      2'b01
`define FLIT_TYPE_HEAD      2'b10
`define FLIT_TYPE_HEAD_TAIL 2'b11
// Slot state encodings
`define PKT_SLOT_EMPTY      2'd0
`define PKT_SLOT_FILLING    2'd1
`define PKT_SLOT_FULL       2'd2
`define PKT_SLOT_DROP       2'd3
`endif

package packet_assembler_pkg;

    localparam int FLIT_W  = `FLIT_WIDTH;
    localparam int MAX_LEN = `MAX_PACKET_LENGHT;

    typedef enum logic [1:0] {
        FT_BODY      = `FLIT_TYPE_BODY,
        FT_TAIL      = `FLIT_TYPE_TAIL,
        FT_HEAD      = `FLIT_TYPE_HEAD,
        FT_HEAD_TAIL = `FLIT_TYPE_HEAD_TAIL
    } flit_type_e;

    typedef enum logic [1:0] {
        SLOT_EMPTY   = `PKT_SLOT_EMPTY,
        SLOT_FILLING = `PKT_SLOT_FILLING,
        SLOT_FULL    = `PKT_SLOT_FULL,
        SLOT_DROP    = `PKT_SLOT_DROP
    } slot_state_e;

    // Extract the type field of a flit.
    function automatic flit_type_e get_flit_type(input logic [FLIT_W-1:0] flit);
        return flit_type_e'(flit[`FLIT_TYPE_BITS]);
    endfunction

endpackage

// File: rtl/packet_slot.sv
// One packet slot: flit storage, flit counter and the EMPTY/FILLING/FULL/DROP
// state machine. The parent decides when this slot is written (wr_en) and when
// its finished packet has been taken downstream (free).

module packet_slot
    import packet_assembler_pkg::*;
#(
    parameter int N_BITS_FLIT_CNT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FLIT_W-1:0]         flit,
    input  logic                      wr_en,
    input  logic                      free,
    output slot_state_e               state,
    output logic [MAX_LEN*FLIT_W-1:0] link,
    output logic [MAX_LEN-1:0]        sel,
    output logic                      drop,
    output logic                      complete
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam logic [N_BITS_FLIT_CNT-1:0] LEN_LIMIT = N_BITS_FLIT_CNT'(MAX_LEN);
    localparam logic [N_BITS_FLIT_CNT-1:0] CNT_ONE   = N_BITS_FLIT_CNT'(1);

    logic [FLIT_W-1:0]          data [MAX_LEN];
    logic [N_BITS_FLIT_CNT-1:0] cnt;
    flit_type_e                 ftype;
    logic                       is_head;
    logic                       fits;
    logic                       store;
    logic [IDX_W-1:0]           store_idx;

    // Decode the incoming flit against the current state: where it lands and
    // whether it closes a packet.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        store     = 1'b0;
        complete  = 1'b0;
        ftype     = get_flit_type(flit);
        is_head   = (ftype == FT_HEAD) || (ftype == FT_HEAD_TAIL);
        fits      = (cnt < LEN_LIMIT);
        store_idx = is_head ? '0 : cnt[IDX_W-1:0];
        if (wr_en) begin
            case (state)
                SLOT_EMPTY: begin
                    store    = is_head;
                    complete = (ftype == FT_HEAD_TAIL);
                end
                SLOT_FILLING: begin
                    store    = is_head || fits;
                    complete = (ftype == FT_HEAD_TAIL) || ((ftype == FT_TAIL) && fits);
                end
                default: ;
            endcase
        end
    end

    // Flit storage; lanes are masked on the way out, so the array needs no reset.
    // NOTE: storage array is deliberately not reset; in_sel masking hides stale contents.
    always_ff @(posedge clk) begin
        if (store) begin
            data[store_idx] <= flit;
        end
    end

    // Slot state machine with flit counter and registered drop pulse.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
        if (!rst) begin
            state <= SLOT_EMPTY;
            cnt   <= '0;
            drop  <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (free) begin
                state <= SLOT_EMPTY;
                cnt   <= '0;
            end else if (wr_en) begin
                case (state)
                    SLOT_EMPTY: begin
                        if (is_head) begin
                            cnt   <= CNT_ONE;
                            state <= (ftype == FT_HEAD_TAIL) ? SLOT_FULL : SLOT_FILLING;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                    SLOT_FILLING: begin
                        if (is_head) begin
                            // New header abandons the partial packet and restarts here.
                            drop  <= 1'b1;
                            cnt   <= CNT_ONE;
                            state <= (ftype == FT_HEAD_TAIL) ? SLOT_FULL : SLOT_FILLING;
                        end else if (fits) begin
                            cnt <= cnt + CNT_ONE;
                            if (ftype == FT_TAIL) begin
                                state <= SLOT_FULL;
                            end
                        end else begin
                            drop  <= 1'b1;
                            cnt   <= '0;
                            state <= SLOT_DROP;
                        end
                    end
                    SLOT_DROP: begin
                        drop <= 1'b1;
                        if (ftype == FT_TAIL) begin
                            state <= SLOT_EMPTY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Valid-lane mask from the count, with unused lanes forced to zero.
    always_comb begin
        sel  = '0;
        link = '0;
        for (int k = 0; k < MAX_LEN; k++) begin
            sel[k] = (N_BITS_FLIT_CNT'(k) < cnt);
            if (sel[k]) begin
                link[k*FLIT_W +: FLIT_W] = data[k];
            end
        end
    end

endmodule

// File: rtl/packet_assembler.sv
// Packet assembler: collects NoC flits into two ping-pong packet slots and
// offers completed packets, in arrival order, to the message queue.
// Define PKT_ASM_ERR_CNT_EN to add the saturating drop counter
// (err_cnt_o / err_clr_i).

module packet_assembler
    import packet_assembler_pkg::*;
#(
    parameter int N_BITS_FLIT_CNT = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [`FLIT_WIDTH-1:0]                    flit_i,
    input  logic                                      flit_valid_i,
    output logic                                      flit_ready_o,
    output logic [`MAX_PACKET_LENGHT*`FLIT_WIDTH-1:0] in_link_o,
    output logic [`MAX_PACKET_LENGHT-1:0]             in_sel_o,
    output logic                                      r_pkt_to_msg_o,
    input  logic                                      g_pkt_to_msg_i,
    output logic                                      drop_o
`ifdef PKT_ASM_ERR_CNT_EN
    ,
    input  logic                                      err_clr_i,
    output logic [15:0]                               err_cnt_o
`endif
);

    logic                      wr_ptr;
    logic                      rd_ptr;
    logic                      accept;
    logic                      take;
    slot_state_e               slot_state [2];
    logic [MAX_LEN*FLIT_W-1:0] slot_link  [2];
    logic [MAX_LEN-1:0]        slot_sel   [2];
    logic                      slot_drop  [2];
    logic                      slot_done  [2];
    logic                      slot_wr    [2];
    logic                      slot_free  [2];

    assign flit_ready_o   = (slot_state[wr_ptr] != SLOT_FULL);
    assign r_pkt_to_msg_o = (slot_state[rd_ptr] == SLOT_FULL);
    assign accept         = flit_valid_i && flit_ready_o;
    assign take           = g_pkt_to_msg_i && r_pkt_to_msg_o;

    assign slot_wr[0]   = accept && !wr_ptr;
    assign slot_wr[1]   = accept &&  wr_ptr;
    assign slot_free[0] = take   && !rd_ptr;
    assign slot_free[1] = take   &&  rd_ptr;

    assign in_link_o = slot_link[rd_ptr];
    assign in_sel_o  = slot_sel[rd_ptr];
    assign drop_o    = slot_drop[0] || slot_drop[1];

    packet_slot #(.N_BITS_FLIT_CNT(N_BITS_FLIT_CNT)) u_slot0 (
        .clk      (clk),
        .rst      (rst),
        .flit     (flit_i),
        .wr_en    (slot_wr[0]),
        .free     (slot_free[0]),
        .state    (slot_state[0]),
        .link     (slot_link[0]),
        .sel      (slot_sel[0]),
        .drop     (slot_drop[0]),
        .complete (slot_done[0])
    );

    packet_slot #(.N_BITS_FLIT_CNT(N_BITS_FLIT_CNT)) u_slot1 (
        .clk      (clk),
        .rst      (rst),
        .flit     (flit_i),
        .wr_en    (slot_wr[1]),
        .free     (slot_free[1]),
        .state    (slot_state[1]),
        .link     (slot_link[1]),
        .sel      (slot_sel[1]),
        .drop     (slot_drop[1]),
        .complete (slot_done[1])
    );

    // Advance the write slot on packet completion and the read slot on grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr ^ (slot_done[0] || slot_done[1]);
            rd_ptr <= rd_ptr ^ take;
        end
    end

`ifdef PKT_ASM_ERR_CNT_EN
    // Saturating count of drop pulses; clear wins over a coincident drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_o <= '0;
        end else if (err_clr_i) begin
            err_cnt_o <= '0;
        end else if (drop_o && (err_cnt_o != 16'hFFFF)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_packet_assembler.sv
// Directed testbench for packet_assembler: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences (lane contents, same-edge
// release/complete, ignored grant, asynchronous reset, error counter).

module tb_packet_assembler;
    import packet_assembler_pkg::*;

    localparam int FW = FLIT_W;
    localparam int ML = MAX_LEN;

    logic              clk;
    logic              rst;
    logic [FW-1:0]     flit_i;
    logic              flit_valid_i;
    logic              flit_ready_o;
    logic [ML*FW-1:0]  in_link_o;
    logic [ML-1:0]     in_sel_o;
    logic              r_pkt_to_msg_o;
    logic              g_pkt_to_msg_i;
    logic              drop_o;
`ifdef PKT_ASM_ERR_CNT_EN
    logic              err_clr_i;
    logic [15:0]       err_cnt_o;
`endif

    packet_assembler dut (
        .clk            (clk),
        .rst            (rst),
        .flit_i         (flit_i),
        .flit_valid_i   (flit_valid_i),
        .flit_ready_o   (flit_ready_o),
        .in_link_o      (in_link_o),
        .in_sel_o       (in_sel_o),
        .r_pkt_to_msg_o (r_pkt_to_msg_o),
        .g_pkt_to_msg_i (g_pkt_to_msg_i),
        .drop_o         (drop_o)
`ifdef PKT_ASM_ERR_CNT_EN
        ,
        .err_clr_i      (err_clr_i),
        .err_cnt_o      (err_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [1:0] ftype;
        logic       grant;
        logic       exp_ready;
        logic       exp_req;
        logic       exp_drop;
        logic [4:0] exp_sel;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void add(input logic v, input logic [1:0] t, input logic g,
                                input logic r, input logic q, input logic d,
                                input logic [4:0] s);
        vec_t e;
        e.valid = v; e.ftype = t; e.grant = g;
        e.exp_ready = r; e.exp_req = q; e.exp_drop = d; e.exp_sel = s;
        tbl.push_back(e);
    endfunction

    function automatic logic [FW-1:0] mk(input logic [1:0] t, input int p);
        logic [FW-1:0] f;
        f = FW'(p);
        f[`FLIT_TYPE_BITS] = t;
        return f;
    endfunction

    task automatic check(input string name, input logic [ML*FW-1:0] act,
                         input logic [ML*FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [FW-1:0] f, input logic g);
        flit_valid_i   = v;
        flit_i         = f;
        g_pkt_to_msg_i = g;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic r, input logic q,
                              input logic d, input logic [4:0] s);
        check({tag, " ready"}, ML*FW'(flit_ready_o), ML*FW'(r));
        check({tag, " req"},   ML*FW'(r_pkt_to_msg_o), ML*FW'(q));
        check({tag, " drop"},  ML*FW'(drop_o), ML*FW'(d));
        check({tag, " sel"},   ML*FW'(in_sel_o), ML*FW'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [ML*FW-1:0] exp_link;
        logic [ML*FW-1:0] snap;
        logic [FW-1:0]    f [5];
        logic [FW-1:0]    hx;

        rst = 1'b0; flit_i = '0; flit_valid_i = 1'b0; g_pkt_to_msg_i = 1'b0;
`ifdef PKT_ASM_ERR_CNT_EN
        err_clr_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_ctrl("reset", 1'b1, 1'b0, 1'b0, 5'b00000);
        check("reset link", in_link_o, '0);
        rst = 1'b1;

        // Single HEAD_TAIL, granted two cycles after accept.
        add(1, FT_HEAD_TAIL, 0, 1, 1, 0, 5'b00001);
        add(0, FT_HEAD_TAIL, 0, 1, 1, 0, 5'b00001);
        add(0, FT_HEAD_TAIL, 1, 1, 0, 0, 5'b00000);
        // Two 5-flit packets with no grant, then two grants.
        add(1, FT_HEAD, 0, 1, 0, 0, 5'b00001);
        add(1, FT_BODY, 0, 1, 0, 0, 5'b00011);
        add(1, FT_BODY, 0, 1, 0, 0, 5'b00111);
        add(1, FT_BODY, 0, 1, 0, 0, 5'b01111);
        add(1, FT_TAIL, 0, 1, 1, 0, 5'b11111);
        add(1, FT_HEAD, 0, 1, 1, 0, 5'b11111);
        add(1, FT_BODY, 0, 1, 1, 0, 5'b11111);
        add(1, FT_BODY, 0, 1, 1, 0, 5'b11111);
        add(1, FT_BODY, 0, 1, 1, 0, 5'b11111);
        add(1, FT_TAIL, 0, 0, 1, 0, 5'b11111);
        add(1, FT_HEAD_TAIL, 0, 0, 1, 0, 5'b11111);
        add(0, FT_HEAD_TAIL, 1, 1, 1, 0, 5'b11111);
        add(0, FT_HEAD_TAIL, 1, 1, 0, 0, 5'b00000);
        // Lone BODY, then an 8-flit packet that overflows.
        add(1, FT_BODY, 0, 1, 0, 1, 5'b00000);
        add(1, FT_HEAD, 0, 1, 0, 0, 5'b00001);
        add(1, FT_BODY, 0, 1, 0, 0, 5'b00011);
        add(1, FT_BODY, 0, 1, 0, 0, 5'b00111);
        add(1, FT_BODY, 0, 1, 0, 0, 5'b01111);
        add(1, FT_BODY, 0, 1, 0, 0, 5'b11111);
        add(1, FT_BODY, 0, 1, 0, 1, 5'b00000);
        add(1, FT_BODY, 0, 1, 0, 1, 5'b00000);
        add(1, FT_TAIL, 0, 1, 0, 1, 5'b00000);
        add(0, FT_BODY, 0, 1, 0, 0, 5'b00000);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].valid, mk(tbl[i].ftype, i), tbl[i].grant);
            check_ctrl($sformatf("vec%0d", i), tbl[i].exp_ready, tbl[i].exp_req,
                       tbl[i].exp_drop, tbl[i].exp_sel);
        end

`ifdef PKT_ASM_ERR_CNT_EN
        check("errcnt after drops", ML*FW'(err_cnt_o), ML*FW'(16'd4));
        step(1'b1, mk(FT_BODY, 7), 1'b0);
        check("errclr setup drop", ML*FW'(drop_o), ML*FW'(1'b1));
        err_clr_i = 1'b1;
        step(1'b0, '0, 1'b0);
        err_clr_i = 1'b0;
        check("errclr beats drop", ML*FW'(err_cnt_o), '0);
        step(1'b0, '0, 1'b0);
        check("errcnt stays clear", ML*FW'(err_cnt_o), '0);
`endif

        // Lane contents of a 5-flit packet held stable until grant.
        f[0] = mk(FT_HEAD, 14'h0A0);
        f[1] = mk(FT_BODY, 14'h0A1);
        f[2] = mk(FT_BODY, 14'h0A2);
        f[3] = mk(FT_BODY, 14'h0A3);
        f[4] = mk(FT_TAIL, 14'h0A4);
        for (int k = 0; k < 5; k++) step(1'b1, f[k], 1'b0);
        exp_link = '0;
        for (int k = 0; k < 5; k++) exp_link[k*FW +: FW] = f[k];
        check_ctrl("pkt5", 1'b1, 1'b1, 1'b0, 5'b11111);
        check("pkt5 lanes", in_link_o, exp_link);
        snap = exp_link;
        hx = mk(FT_HEAD_TAIL, 14'h0B5);
        step(1'b1, hx, 1'b0);
        check("hold0 lanes", in_link_o, snap);
        for (int c = 1; c < 3; c++) begin
            step(1'b0, '0, 1'b0);
            check($sformatf("hold%0d lanes", c), in_link_o, snap);
            check($sformatf("hold%0d req", c), ML*FW'(r_pkt_to_msg_o), ML*FW'(1'b1));
        end
        step(1'b0, '0, 1'b1);
        exp_link = '0;
        exp_link[FW-1:0] = hx;
        check_ctrl("next pkt", 1'b1, 1'b1, 1'b0, 5'b00001);
        check("next pkt lanes", in_link_o, exp_link);

        // Grant with no request pending must be ignored.
        step(1'b0, '0, 1'b1);
        check("release2 req", ML*FW'(r_pkt_to_msg_o), '0);
        step(1'b0, '0, 1'b1);
        check("idle grant req", ML*FW'(r_pkt_to_msg_o), '0);
        hx = mk(FT_HEAD_TAIL, 14'h0C6);
        step(1'b1, hx, 1'b0);
        exp_link = '0;
        exp_link[FW-1:0] = hx;
        check_ctrl("after idle grant", 1'b1, 1'b1, 1'b0, 5'b00001);
        check("after idle grant lanes", in_link_o, exp_link);
        step(1'b0, '0, 1'b1);
        check("drain req", ML*FW'(r_pkt_to_msg_o), '0);

        // Release of one slot on the same edge as tail completion in the other.
        step(1'b1, mk(FT_HEAD_TAIL, 14'h0D0), 1'b0);
        check("same-edge A req", ML*FW'(r_pkt_to_msg_o), ML*FW'(1'b1));
        f[0] = mk(FT_HEAD, 14'h0D1);
        f[1] = mk(FT_TAIL, 14'h0D2);
        step(1'b1, f[0], 1'b0);
        step(1'b1, f[1], 1'b1);
        exp_link = '0;
        exp_link[FW-1:0]    = f[0];
        exp_link[2*FW-1:FW] = f[1];
        check_ctrl("same-edge B", 1'b1, 1'b1, 1'b0, 5'b00011);
        check("same-edge B lanes", in_link_o, exp_link);
        step(1'b0, '0, 1'b1);
        check("same-edge drain req", ML*FW'(r_pkt_to_msg_o), '0);

        // Asynchronous reset with one FULL and one partial packet pending.
        step(1'b1, mk(FT_HEAD_TAIL, 14'h0E0), 1'b0);
        step(1'b1, mk(FT_HEAD, 14'h0E1), 1'b0);
        step(1'b1, mk(FT_HEAD, 14'h0E2), 1'b0);
        check("restart drop", ML*FW'(drop_o), ML*FW'(1'b1));
        #3;
        rst = 1'b0;
        #1;
        check_ctrl("async rst", 1'b1, 1'b0, 1'b0, 5'b00000);
        check("async rst lanes", in_link_o, '0);
`ifdef PKT_ASM_ERR_CNT_EN
        check("async rst errcnt", ML*FW'(err_cnt_o), '0);
`endif
        flit_valid_i = 1'b1;
        flit_i = mk(FT_HEAD_TAIL, 14'h0E3);
        @(posedge clk);
        #1;
        check_ctrl("rst held", 1'b1, 1'b0, 1'b0, 5'b00000);
        #3;
        rst = 1'b1;
        hx = mk(FT_HEAD_TAIL, 14'h0F0);
        step(1'b1, hx, 1'b0);
        exp_link = '0;
        exp_link[FW-1:0] = hx;
        check_ctrl("post rst", 1'b1, 1'b1, 1'b0, 5'b00001);
        check("post rst lanes", in_link_o, exp_link);
        step(1'b0, '0, 1'b1);
        check_ctrl("post rst drain", 1'b1, 1'b0, 1'b0, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/packet_assembler.md
PACKET_ASSEMBLER -- requirements
Module: packet_assembler

Interface
REQ-001 SHALL have parameter N_BITS_FLIT_CNT, default 3, width of the per-slot flit counter; it SHALL satisfy 2^N_BITS_FLIT_CNT > `MAX_PACKET_LENGHT.
REQ-002 SHALL have these ports:
- clk  in  1  sole clock.
- rst  in  1  reset, asynchronous, active-low.
- flit_i  in  `FLIT_WIDTH  flit from the NoC input port.
- flit_valid_i  in  1  flit_i valid.
- flit_ready_o  out  1  flit accepted on an edge where valid and ready are both high.
- in_link_o  out  `MAX_PACKET_LENGHT*`FLIT_WIDTH  packet of the read slot; flit k in bits [(k+1)*`FLIT_WIDTH-1:k*`FLIT_WIDTH].
- in_sel_o  out  `MAX_PACKET_LENGHT  bit k high means flit k is valid.
- r_pkt_to_msg_o  out  1  storage request to message_queue.
- g_pkt_to_msg_i  in  1  grant from message_queue; a one-cycle pulse.
- drop_o  out  1  one-cycle pulse when a flit is discarded.

Function
REQ-003 SHALL hold two packet slots, used in ping-pong order: wr_ptr selects the slot being filled and rd_ptr the slot offered downstream; packets SHALL leave in arrival order.
REQ-004 Each slot SHALL be in one of four states: EMPTY, FILLING, FULL, DROP.
REQ-005 Flit type SHALL be decoded from flit_i[`FLIT_TYPE_BITS].
REQ-006 Slot transitions on an accepted flit:
- HEAD_TAIL in EMPTY: store at index 0, go FULL, toggle wr_ptr.
- HEAD in EMPTY: store at index 0, go FILLING.
- BODY in FILLING: store at the next index.
- TAIL in FILLING: store at the next index, go FULL, toggle wr_ptr.
REQ-007 Any other accepted flit type in EMPTY SHALL be discarded with drop_o, and the slot SHALL stay EMPTY.
REQ-008 HEAD or HEAD_TAIL while FILLING SHALL discard the partial packet and restart the slot with the new flit; drop_o SHALL pulse.
REQ-009 A BODY or TAIL that would land at index ≥ `MAX_PACKET_LENGHT SHALL put the slot in DROP.
REQ-010 In DROP, every flit SHALL be discarded with drop_o; TAIL SHALL return the slot to EMPTY.
REQ-011 flit_ready_o SHALL be high unless slot[wr_ptr] is FULL; it SHALL be combinational from registered state only.
REQ-012 r_pkt_to_msg_o SHALL equal (slot[rd_ptr]==FULL), registered-state only; a tail accepted at edge N SHALL give r_pkt_to_msg_o high in cycle N+1 when that slot is rd_ptr.
REQ-013 in_link_o and in_sel_o SHALL remain stable while r_pkt_to_msg_o is high, up to and including the cycle in which g_pkt_to_msg_i is high.
REQ-014 On an edge with g_pkt_to_msg_i high and r_pkt_to_msg_o high, slot[rd_ptr] SHALL go EMPTY and rd_ptr SHALL toggle.
REQ-015 g_pkt_to_msg_i while r_pkt_to_msg_o is low SHALL be ignored.
REQ-016 in_sel_o bit k SHALL be high for k < stored count; unused flit lanes of in_link_o SHALL read 0.
REQ-017 Same-edge release of slot A and tail completion into slot B SHALL both take effect.
REQ-018 With both slots FULL, flit_ready_o SHALL be low; it SHALL rise in the cycle after the release edge.

Reset
REQ-019 rst low SHALL immediately, regardless of the clock, set:
- both slots EMPTY, wr_ptr=0, rd_ptr=0, all counters 0;
- r_pkt_to_msg_o=0, drop_o=0, flit_ready_o=1, in_sel_o=0.
REQ-020 Reset mid-packet SHALL discard all partial and FULL packets without emitting drop_o.

Configuration
REQ-021 With PKT_ASM_ERR_CNT_EN defined:
- SHALL add output err_cnt_o (16 bits), counting drop_o pulses and saturating at 16'hFFFF;
- SHALL add input err_clr_i, which zeroes the count on the next edge; a simultaneous drop SHALL be ignored.
REQ-022 Without PKT_ASM_ERR_CNT_EN, neither port nor the counter logic SHALL exist, and all other behaviour SHALL be identical.

Structure
REQ-023 Flit type codes, `FLIT_TYPE_BITS, `FLIT_WIDTH and `MAX_PACKET_LENGHT SHALL come only from NIC-defines.v; slot state encodings SHALL be added there.
REQ-024 A single sub-module packet_slot SHALL implement one slot's storage, counter and state machine; it SHALL be instantiated twice.

Verification (MAX_PACKET_LENGHT=5)
REQ-025 HEAD_TAIL flit, grant 2 cycles later -> r_pkt_to_msg_o high the cycle after accept; in_sel_o=5'b00001; slot EMPTY after the grant edge.
REQ-026 HEAD, 3 BODY, TAIL back-to-back -> in_sel_o=5'b11111; in_link_o lanes match in order; held stable until the grant.
REQ-027 Two 5-flit packets with no grant -> flit_ready_o low after the 10th flit; one grant -> ready high the next cycle, then r_pkt_to_msg_o re-asserts for packet 2.
REQ-028 BODY with no HEAD, then HEAD+6 BODY+TAIL -> drop_o on the lone BODY and on flits 6–8; no request issued; err_cnt_o=4 when PKT_ASM_ERR_CNT_EN is defined.
REQ-029 rst low mid-packet and asynchronous to clk -> outputs take their reset values immediately; a following HEAD_TAIL is assembled normally into slot 0.
